// File: rtl/keypad_fifo_reader.sv
// Keypad front end: debounces the scanner's key code, queues press events in a
// 4-entry FIFO and exposes data/status registers to a CPU read port.
module keypad_fifo_reader #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  key_code,
   input  logic        rd_en,
   input  logic        addr,
   output logic [31:0] rd_data,
   output logic        irq
);

   localparam int unsigned CODE_W  = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned PTR_W   = 2;
   localparam int unsigned COUNT_W = 3;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ENTRIES = 4;

   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(FIFO_DEPTH);

   logic [CODE_W-1:0]  r_cand;
   logic [CNT_W-1:0]   r_cnt;
   logic [CODE_W-1:0]  r_stable;

   logic [CODE_W-1:0]  r_mem [ENTRIES];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [COUNT_W-1:0] r_count;
   logic               r_ovf;
   logic [DATA_W-1:0]  r_rd_data;

   logic               w_match;
   logic               w_load;
   logic               w_press;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_status_rd;
   logic [DATA_W-1:0]  w_status;
   logic [DATA_W-1:0]  w_head;

   // Debounce decode: stable code updates once the candidate has been seen long enough
   always_comb begin
      w_match = (key_code == r_cand);
      w_load  = w_match && (r_cnt == CNT_MAX) && (r_cand != r_stable);
      w_press = w_load && (r_cand != '0);
   end

   // FIFO control: a pop in the same cycle frees a slot for a push into a full FIFO
   always_comb begin
      w_empty     = (r_count == '0);
      w_full      = (r_count == DEPTH_C);
      w_pop       = rd_en && !addr && !w_empty;
      w_push      = w_press && (!w_full || w_pop);
      w_drop      = w_press && w_full && !w_pop;
      w_status_rd = rd_en && addr;
      w_status    = {26'b0, r_count, r_ovf, w_full, w_empty};
      w_head      = {24'b0, r_mem[r_rd_ptr]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cand   <= '0;
         r_cnt    <= '0;
         r_stable <= '0;
      end else if (!w_match) begin
         r_cand <= key_code;
         r_cnt  <= '0;
      end else if (r_cnt < CNT_MAX) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_load) begin
         r_stable <= r_cand;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= r_cand;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + COUNT_W'(1);
            2'b01:   r_count <= r_count - COUNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Overflow is sticky; a new drop wins over a clearing status read
   always_ff @(posedge clk) begin
      if (!rst_n)           r_ovf <= 1'b0;
      else if (w_drop)      r_ovf <= 1'b1;
      else if (w_status_rd) r_ovf <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)           r_rd_data <= '0;
      else if (w_status_rd) r_rd_data <= w_status;
      else if (rd_en)       r_rd_data <= w_empty ? '0 : w_head;
   end

   assign rd_data = r_rd_data;
   assign irq     = !w_empty;

endmodule

// File: tb/tb_keypad_fifo_reader.sv
// Directed bench for keypad_fifo_reader with DEBOUNCE_CYCLES=4.
module tb_keypad_fifo_reader;

   localparam int unsigned DB = 4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  key_code;
   logic        rd_en;
   logic        addr;
   logic [31:0] rd_data;
   logic        irq;

   int n_asrt = 0;
   int n_fail = 0;
   logic [31:0] v;

   keypad_fifo_reader #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_code (key_code),
      .rd_en    (rd_en),
      .addr     (addr),
      .rd_data  (rd_data),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic a, output logic [31:0] d);
      rd_en = 1'b1;
      addr  = a;
      tick(1);
      rd_en = 1'b0;
      addr  = 1'b0;
      d     = rd_data;
   endtask

   // Debounced press (event on the DB+1'th edge) followed by a full release
   task automatic press(input logic [7:0] code);
      key_code = code;
      tick(DB + 1);
      key_code = 8'h00;
      tick(DB + 1);
   endtask

   initial begin
      rst_n = 1'b0; key_code = 8'h00; rd_en = 1'b0; addr = 1'b0;
      tick(2);
      rst_n = 1'b1;
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_rd_data", rd_data, 32'h0);
      do_read(1'b1, v);
      check("reset_status", v, 32'h1);

      // Single press: push lands on the 5th edge
      key_code = 8'h35;
      tick(4);
      check("press_before_5th", {31'b0, irq}, 32'h0);
      tick(1);
      check("press_on_5th", {31'b0, irq}, 32'h1);
      tick(5);
      key_code = 8'h00;
      tick(DB + 1);
      do_read(1'b1, v);
      check("single_status", v, 32'h0000_0008);
      do_read(1'b0, v);
      check("single_data", v, 32'h35);
      check("single_irq_fall", {31'b0, irq}, 32'h0);
      tick(3);
      check("rd_data_hold", rd_data, 32'h35);

      // Too-short hold is rejected
      key_code = 8'h41;
      tick(3);
      key_code = 8'h00;
      tick(6);
      do_read(1'b1, v);
      check("short_status", v, 32'h1);

      // Overflow, then drain past empty
      press(8'h31); press(8'h32); press(8'h33); press(8'h34); press(8'h35);
      do_read(1'b1, v);
      check("ovf_status", v, 32'h26);
      do_read(1'b0, v); check("drain0", v, 32'h31);
      do_read(1'b0, v); check("drain1", v, 32'h32);
      do_read(1'b0, v); check("drain2", v, 32'h33);
      do_read(1'b0, v); check("drain3", v, 32'h34);
      do_read(1'b0, v); check("drain_empty", v, 32'h0);
      do_read(1'b1, v); check("drain_status", v, 32'h1);

      // Full FIFO: press coincides with a data read
      press(8'h31); press(8'h32); press(8'h33); press(8'h34);
      key_code = 8'h36;
      tick(DB);
      do_read(1'b0, v);
      check("full_pushpop_data", v, 32'h31);
      do_read(1'b1, v);
      check("full_pushpop_status", v, 32'h22);
      key_code = 8'h00;
      tick(DB + 1);
      do_read(1'b0, v); check("fp_drain0", v, 32'h32);
      do_read(1'b0, v); check("fp_drain1", v, 32'h33);
      do_read(1'b0, v); check("fp_drain2", v, 32'h34);
      do_read(1'b0, v); check("fp_drain3", v, 32'h36);

      // Overflow coinciding with a status read keeps overflow set
      press(8'h31); press(8'h32); press(8'h33); press(8'h34);
      key_code = 8'h36;
      tick(DB);
      do_read(1'b1, v);
      check("ovf_prio_sample", v, 32'h22);
      do_read(1'b1, v);
      check("ovf_prio_set", v, 32'h26);
      do_read(1'b1, v);
      check("ovf_prio_cleared", v, 32'h22);
      key_code = 8'h00;
      tick(DB + 1);
      repeat (4) do_read(1'b0, v);
      check("ovf_prio_last", v, 32'h34);

      // Empty FIFO: push coincides with a data read
      key_code = 8'h3A;
      tick(DB);
      do_read(1'b0, v);
      check("empty_pushpop_data", v, 32'h0);
      check("empty_pushpop_irq", {31'b0, irq}, 32'h1);
      key_code = 8'h00;
      tick(DB + 1);
      do_read(1'b0, v);
      check("empty_pushpop_entry", v, 32'h3A);

      // Rollover between two codes, then re-press after release
      key_code = 8'h37;
      tick(DB + 1);
      key_code = 8'h38;
      tick(DB + 1);
      key_code = 8'h00;
      tick(DB + 1);
      press(8'h38);
      do_read(1'b1, v); check("roll_status", v, 32'h18);
      do_read(1'b0, v); check("roll0", v, 32'h37);
      do_read(1'b0, v); check("roll1", v, 32'h38);
      do_read(1'b0, v); check("roll2", v, 32'h38);

      // Reset mid-debounce with two entries queued
      press(8'h31); press(8'h32);
      key_code = 8'h39;
      tick(3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("rst_mid_irq", {31'b0, irq}, 32'h0);
      check("rst_mid_rd_data", rd_data, 32'h0);
      key_code = 8'h00;
      do_read(1'b1, v);
      check("rst_mid_status", v, 32'h1);
      tick(DB + 2);
      do_read(1'b1, v);
      check("rst_mid_no_push", v, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
